instruction_controller: RTL and testbench

Instruction register, decoder and Moore control FSM that sits directly upstream of `datapath`. It drives every datapath control input, `readnum`, `writenum`, `write` and the immediate on `datapath_in`. It latches one 16-bit instruction and sequences it through register fetch, compute and write-back. A high `w` tells the surrounding system it is ready for the next instruction.

---
 rtl/instruction_controller_if.sv | 33 +++
 rtl/instruction_controller.sv | 132 +++++++++++++
 tb/tb_instruction_controller.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/instruction_controller_if.sv
// Instruction input and datapath control bundle between the instruction
// controller (master) and the datapath/surrounding system (slave).
interface instruction_controller_if;
  logic [15:0] in;
  logic        load;
  logic        s;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        vsel;
  logic [15:0] datapath_in;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;

  modport master (
    input  in, load, s,
    output w, readnum, writenum, write, vsel, datapath_in,
           loada, loadb, loadc, loads, asel, bsel, shift, ALUop
  );

  modport slave (
    output in, load, s,
    input  w, readnum, writenum, write, vsel, datapath_in,
           loada, loadb, loadc, loads, asel, bsel, shift, ALUop
  );
endinterface

// File: rtl/instruction_controller.sv
// Instruction register, decoder and Moore control FSM driving the datapath
// through fetch, compute and write-back for one latched instruction.
module instruction_controller (
  input  logic                      clk,
  input  logic                      reset_n,
  instruction_controller_if.master  bus
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_COMPUTE,
    S_WRITE_REG,
    S_WRITE_IMM
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [15:0] ir;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [1:0] sh;
  logic [2:0] rm;

  logic is_mov_imm;
  logic is_mov_reg;
  logic is_alu;
  logic is_cmp;
  logic is_mvn;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_cmp     = is_alu && (op == 2'b01);
  assign is_mvn     = is_alu && (op == 2'b11);

  // IR only accepts a new word while idle, so it is stable for the whole instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir <= 16'h0000;
    end else if (state == S_WAIT && bus.load) begin
      ir <= bus.in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_WAIT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_WAIT:      next_state = bus.s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        if (is_mov_imm)               next_state = S_WRITE_IMM;
        else if (is_mov_reg || is_mvn) next_state = S_GET_B;
        else if (is_alu)              next_state = S_GET_A;
        else                          next_state = S_WAIT;
      end
      S_GET_A:     next_state = S_GET_B;
      S_GET_B:     next_state = S_COMPUTE;
      S_COMPUTE:   next_state = is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: next_state = S_WAIT;
      S_WRITE_IMM: next_state = S_WAIT;
      default:     next_state = S_WAIT;
    endcase
  end

  assign bus.datapath_in = {{8{ir[7]}}, ir[7:0]};

  // Controls depend on state and IR only, never on s/load.
  always_comb begin
    bus.w        = 1'b0;
    bus.readnum  = 3'b000;
    bus.writenum = 3'b000;
    bus.write    = 1'b0;
    bus.vsel     = 1'b0;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.loadc    = 1'b0;
    bus.loads    = 1'b0;
    bus.asel     = 1'b0;
    bus.bsel     = 1'b0;
    bus.shift    = 2'b00;
    bus.ALUop    = 2'b00;
    case (state)
      S_WAIT: bus.w = 1'b1;
      S_GET_A: begin
        bus.readnum = rn;
        bus.loada   = 1'b1;
      end
      S_GET_B: begin
        bus.readnum = rm;
        bus.loadb   = 1'b1;
      end
      S_COMPUTE: begin
        bus.shift = sh;
        bus.loadc = 1'b1;
        bus.ALUop = is_alu ? op : 2'b00;
        bus.asel  = is_mov_reg || is_mvn;
        bus.loads = is_cmp;
      end
      S_WRITE_REG: begin
        bus.writenum = rd;
        bus.write    = 1'b1;
      end
      S_WRITE_IMM: begin
        bus.vsel     = 1'b1;
        bus.writenum = rn;
        bus.write    = 1'b1;
      end
      default: bus.w = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_instruction_controller.sv
// Directed-vector bench for instruction_controller: checks the Moore control
// vector cycle by cycle against hand-computed values for each instruction.
module tb_instruction_controller;

  logic clk;
  logic reset_n;
  int   assertCount;
  int   failCount;

  instruction_controller_if bus ();

  instruction_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector layout: {w, readnum, writenum, write, vsel, loada, loadb, loadc, loads, asel, bsel, shift, ALUop}
  function automatic logic [18:0] pack(
    input logic w, input logic [2:0] rn, input logic [2:0] wn,
    input logic wr, input logic vs, input logic la, input logic lb,
    input logic lc, input logic ls, input logic as, input logic bs,
    input logic [1:0] sh, input logic [1:0] alu);
    return {w, rn, wn, wr, vs, la, lb, lc, ls, as, bs, sh, alu};
  endfunction

  function automatic logic [18:0] observed();
    return pack(bus.w, bus.readnum, bus.writenum, bus.write, bus.vsel,
                bus.loada, bus.loadb, bus.loadc, bus.loads,
                bus.asel, bus.bsel, bus.shift, bus.ALUop);
  endfunction

  localparam logic [18:0] V_WAIT = 19'b1_000_000_0_0_0_0_0_0_0_0_00_00;
  localparam logic [18:0] V_IDLE = 19'b0_000_000_0_0_0_0_0_0_0_0_00_00;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present in/load/s for exactly one active edge, then release them.
  task automatic applyStimulus(input logic [15:0] word, input logic ld, input logic st);
    bus.in   = word;
    bus.load = ld;
    bus.s    = st;
    step();
    bus.load = 1'b0;
    bus.s    = 1'b0;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset_n     = 1'b0;
    bus.in      = 16'h0000;
    bus.load    = 1'b0;
    bus.s       = 1'b0;

    #3;
    checkOutput("reset_ctrl", 32'(observed()), 32'(V_WAIT));
    checkOutput("reset_imm", 32'(bus.datapath_in), 32'h0);
    #4 reset_n = 1'b1;
    step();

    // MOV R0,#7: load first, then start separately
    applyStimulus(16'hD007, 1'b1, 1'b0);
    checkOutput("mov7_loaded_wait", 32'(observed()), 32'(V_WAIT));
    checkOutput("mov7_imm", 32'(bus.datapath_in), 32'h0007);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("mov7_decode", 32'(observed()), 32'(V_IDLE));
    step();
    checkOutput("mov7_write_imm", 32'(observed()),
                32'(pack(0, 3'd0, 3'd0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)));
    step();
    checkOutput("mov7_done", 32'(observed()), 32'(V_WAIT));

    // MOV R3,#-1 with load and s together
    applyStimulus(16'hD3FF, 1'b1, 1'b1);
    checkOutput("movm1_decode", 32'(observed()), 32'(V_IDLE));
    step();
    checkOutput("movm1_write_imm", 32'(observed()),
                32'(pack(0, 3'd0, 3'd3, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)));
    checkOutput("movm1_imm", 32'(bus.datapath_in), 32'hFFFF);
    step();
    checkOutput("movm1_done", 32'(observed()), 32'(V_WAIT));

    // ADD R2,R1,R0,LSL#1 with s/load pulsed while busy
    applyStimulus(16'hA148, 1'b1, 1'b1);
    checkOutput("add_decode", 32'(observed()), 32'(V_IDLE));
    bus.in = 16'hD3FF; bus.load = 1'b1; bus.s = 1'b1;
    step();
    checkOutput("add_get_a", 32'(observed()),
                32'(pack(0, 3'd1, 3'd0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00)));
    step();
    bus.load = 1'b0; bus.s = 1'b0;
    checkOutput("add_get_b", 32'(observed()),
                32'(pack(0, 3'd0, 3'd0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00)));
    step();
    checkOutput("add_compute", 32'(observed()),
                32'(pack(0, 3'd0, 3'd0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b01, 2'b00)));
    step();
    checkOutput("add_write_reg", 32'(observed()),
                32'(pack(0, 3'd0, 3'd2, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)));
    checkOutput("add_ir_held", 32'(bus.datapath_in), 32'h0048);
    step();
    checkOutput("add_done", 32'(observed()), 32'(V_WAIT));

    // CMP R0,R0: no write-back, 4-cycle latency
    applyStimulus(16'hA800, 1'b1, 1'b1);
    checkOutput("cmp_decode", 32'(observed()), 32'(V_IDLE));
    step();
    checkOutput("cmp_get_a", 32'(observed()),
                32'(pack(0, 3'd0, 3'd0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00)));
    step();
    checkOutput("cmp_get_b", 32'(observed()),
                32'(pack(0, 3'd0, 3'd0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00)));
    step();
    checkOutput("cmp_compute", 32'(observed()),
                32'(pack(0, 3'd0, 3'd0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b01)));
    step();
    checkOutput("cmp_done", 32'(observed()), 32'(V_WAIT));

    // MVN R7,R1: skips GET_A, zero A operand
    applyStimulus(16'hB8E1, 1'b1, 1'b1);
    step();
    checkOutput("mvn_get_b", 32'(observed()),
                32'(pack(0, 3'd1, 3'd0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00)));
    step();
    checkOutput("mvn_compute", 32'(observed()),
                32'(pack(0, 3'd0, 3'd0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b11)));
    step();
    checkOutput("mvn_write_reg", 32'(observed()),
                32'(pack(0, 3'd0, 3'd7, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)));
    step();
    checkOutput("mvn_done", 32'(observed()), 32'(V_WAIT));

    // MOV R5,R3,LSR#1: ALUop forced to ADD with zero A
    applyStimulus(16'hC0B3, 1'b1, 1'b1);
    step();
    checkOutput("movr_get_b", 32'(observed()),
                32'(pack(0, 3'd3, 3'd0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00)));
    step();
    checkOutput("movr_compute", 32'(observed()),
                32'(pack(0, 3'd0, 3'd0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b10, 2'b00)));
    step();
    checkOutput("movr_write_reg", 32'(observed()),
                32'(pack(0, 3'd0, 3'd5, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)));
    step();
    checkOutput("movr_done", 32'(observed()), 32'(V_WAIT));

    // AND R5,R2,R0
    applyStimulus(16'hB2A0, 1'b1, 1'b1);
    step();
    checkOutput("and_get_a", 32'(observed()),
                32'(pack(0, 3'd2, 3'd0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00)));
    step();
    step();
    checkOutput("and_compute", 32'(observed()),
                32'(pack(0, 3'd0, 3'd0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b10)));
    step();
    step();
    checkOutput("and_done", 32'(observed()), 32'(V_WAIT));

    // Illegal encodings return to WAIT after DECODE
    applyStimulus(16'h0000, 1'b1, 1'b1);
    checkOutput("ill0_decode", 32'(observed()), 32'(V_IDLE));
    step();
    checkOutput("ill0_done", 32'(observed()), 32'(V_WAIT));
    applyStimulus(16'hC800, 1'b1, 1'b1);
    checkOutput("ill1_decode", 32'(observed()), 32'(V_IDLE));
    step();
    checkOutput("ill1_done", 32'(observed()), 32'(V_WAIT));

    // Reset during COMPUTE of an ADD aborts at once
    applyStimulus(16'hA148, 1'b1, 1'b1);
    step();
    step();
    step();
    checkOutput("rst_pre_compute", 32'(observed()),
                32'(pack(0, 3'd0, 3'd0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b01, 2'b00)));
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_ctrl", 32'(observed()), 32'(V_WAIT));
    checkOutput("rst_mid_imm", 32'(bus.datapath_in), 32'h0);
    #2 reset_n = 1'b1;
    step();
    checkOutput("rst_after", 32'(observed()), 32'(V_WAIT));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
